alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Sequential ALU issue/control unit that drives the processor's combinational 32-bit ALU. Accepts an operation (ALUOp class, R-type funct, two operands) over a valid/ready handshake and decodes it to the ALU's 4-bit select code. Presents registered operands to the ALU for one cycle, captures result and zero flag, and returns them over a second valid/ready handshake. Emulates set-on-less-than, which the ALU lacks, using a subtract pass.

## Interface
Parameters: none.
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on clk rising edge
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- alu_op  input  2  class: 00 add, 01 sub (beq), 10 R-type by funct, 11 sub with inverted zero (bne)
- funct  input  6  R-type function field, used only when alu_op=10
- a, b  input  32  operands
- alu_op1, alu_op2  output  32  to ALU operand inputs
- alu_sel  output  4  to ALU select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
- alu_res  input  32  from ALU result
- alu_zf  input  1  from ALU zero flag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  captured result
- zero  output  1  zero/branch flag (inverted for alu_op=11)
- err  output  1  illegal funct for this request

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a->alu_op1, b->alu_op2, decoded code->alu_sel, latch alu_op/funct; go EXEC.
- Decode, alu_op=10: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0110 (SLT, see Configuration); any other funct illegal, alu_sel=0010.
- EXEC: ALU settles on registered inputs; at end of cycle capture into result/zero/err; go DONE.
- Capture rules: normal op: result=alu_res, zero=alu_zf. alu_op=11: zero=~alu_zf. SLT: result={31'b0, alu_res[31]^ovf}, ovf=(a[31]!=b[31])&&(alu_res[31]!=a[31]); zero=(result==0). Illegal: result=0, zero=0, err=1; otherwise err=0.
- DONE: out_valid=1; result/zero/err held stable until out_valid&&out_ready, then go IDLE.
- in_ready=0 in EXEC and DONE; no bypass, no overlap.
- alu_op1/alu_op2/alu_sel hold last values outside EXEC.
- All arithmetic 32-bit, modulo 2^32; ALU carry not observed.

## Timing
- Reset (rst_n low at a clk edge): state IDLE; alu_op1=0, alu_op2=0, alu_sel=0000, result=0, zero=0, err=0, out_valid=0. in_ready=0 while rst_n low, 1 in first cycle after release.
- Accept at edge E0 -> out_valid high after edge E1 (latency 2 edges).
- Minimum 3 cycles per operation when out_ready tied high (accept, EXEC, DONE handshake).
- out_ready low in DONE: stall indefinitely, outputs unchanged.
- in_valid asserted while in_ready=0: ignored, no latch.
- Reset mid-EXEC or mid-DONE: in-flight operation discarded, no out_valid.
- out_valid/in_ready never both high.

## Configuration
- ALU_CTRL_SLT_EN defined: funct 101010 executes SLT emulation as above.
- Not defined: funct 101010 treated as illegal (result=0, zero=0, err=1); no sign/overflow logic synthesized.

## Test plan
- Reset then R-type add, a=5, b=7, funct=100000, out_ready=1 -> alu_sel=0010 in EXEC, result=12, zero=0, err=0, out_valid 2 edges after accept.
- alu_op=01, a=b=0x1234 -> alu_sel=0110, result=0, zero=1; alu_op=11 same operands -> zero=0.
- SLT (macro on): a=0xFFFFFFFF, b=1 -> result=1; a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow case); macro off -> err=1, result=0.
- Illegal funct 000000 -> err=1, result=0, zero=0; following valid NOR a=0, b=0 -> result=0xFFFFFFFF, err=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, new in_valid ignored; out_ready=1 -> transfer, in_ready=1 next cycle.
- rst_n low during EXEC -> next cycle out_valid=0, result=0, in_ready=1 after release.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
//   Sequential issue/control unit for a combinational 32-bit ALU.
//   A request (ALUOp class, funct, operands) is accepted on an in_valid/in_ready
//   handshake. Its operands and decoded 4-bit select are held in registers and
//   shown to the ALU for one cycle (EXEC). The ALU result and zero flag are
//   captured and returned on an out_valid/out_ready handshake (DONE).
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake
//   alu_op[1:0]           00 add, 01 sub, 10 R-type by funct, 11 sub (bne)
//   funct[5:0]            R-type function field (alu_op=10 only)
//   a, b[31:0]            operands
//   alu_op1, alu_op2      registered operands to the ALU
//   alu_sel[3:0]          registered ALU select (AND/OR/ADD/SUB/NOR)
//   alu_res, alu_zf       ALU result and zero flag
//   out_valid / out_ready result handshake
//   result, zero, err     captured result, zero/branch flag, illegal funct
//
// Configuration
//   ALU_CTRL_SLT_EN  when defined, funct 101010 runs set-on-less-than via a
//                    subtract pass; otherwise it is decoded as illegal.
// -----------------------------------------------------------------------------
module alu_ctrl_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_res,
    input  logic        alu_zf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        err
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state_q;
    logic [31:0] alu_op1_q, alu_op2_q, result_q;
    logic [3:0]  alu_sel_q;
    logic        zero_q, err_q, out_valid_q;
    logic        inv_q;   // request was alu_op=11: branch flag is inverted
    logic        ill_q;   // request carried an illegal funct

    // Decode of the incoming request.
    logic [3:0]  sel_d;
    logic        ill_d;
`ifdef ALU_CTRL_SLT_EN
    logic        slt_d, slt_q;
`endif

    always_comb begin
        sel_d = SEL_ADD;
        ill_d = 1'b0;
`ifdef ALU_CTRL_SLT_EN
        slt_d = 1'b0;
`endif
        case (alu_op)
            2'b00: sel_d = SEL_ADD;
            2'b01,
            2'b11: sel_d = SEL_SUB;
            default: begin
                case (funct)
                    6'b100000: sel_d = SEL_ADD;
                    6'b100010: sel_d = SEL_SUB;
                    6'b100100: sel_d = SEL_AND;
                    6'b100101: sel_d = SEL_OR;
                    6'b100111: sel_d = SEL_NOR;
`ifdef ALU_CTRL_SLT_EN
                    6'b101010: begin
                        sel_d = SEL_SUB;
                        slt_d = 1'b1;
                    end
`endif
                    default:   ill_d = 1'b1;  // select stays ADD
                endcase
            end
        endcase
    end

    // Values captured at the end of EXEC.
    logic [31:0] cap_res;
    logic        cap_zero, cap_err;
`ifdef ALU_CTRL_SLT_EN
    logic        ovf, lt;
`endif

    always_comb begin
        cap_res  = alu_res;
        cap_zero = inv_q ? ~alu_zf : alu_zf;
        cap_err  = 1'b0;
`ifdef ALU_CTRL_SLT_EN
        // Signed a<b from a-b: the sign bit is wrong exactly when the
        // subtract overflowed (operand signs differ, result sign != a's).
        ovf = (alu_op1_q[31] != alu_op2_q[31]) && (alu_res[31] != alu_op1_q[31]);
        lt  = alu_res[31] ^ ovf;
        if (slt_q) begin
            cap_res  = {31'b0, lt};
            cap_zero = ~lt;
        end
`endif
        if (ill_q) begin
            cap_res  = '0;
            cap_zero = 1'b0;
            cap_err  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_sel_q   <= SEL_AND;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            inv_q       <= 1'b0;
            ill_q       <= 1'b0;
`ifdef ALU_CTRL_SLT_EN
            slt_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_op1_q <= a;
                        alu_op2_q <= b;
                        alu_sel_q <= sel_d;
                        inv_q     <= (alu_op == 2'b11);
                        ill_q     <= ill_d;
`ifdef ALU_CTRL_SLT_EN
                        slt_q     <= slt_d;
`endif
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= cap_res;
                    zero_q      <= cap_zero;
                    err_q       <= cap_err;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so no request is advertised while reset is held.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign alu_op1   = alu_op1_q;
    assign alu_op2   = alu_op2_q;
    assign alu_sel   = alu_sel_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic [31:0] alu_op1, alu_op2;
    logic [3:0]  alu_sel;
    logic [31:0] alu_res;
    logic        alu_zf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_zf(alu_zf),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .err(err)
    );

    // Reference combinational ALU the unit drives.
    always_comb begin
        case (alu_sel)
            4'b0000: alu_res = alu_op1 & alu_op2;
            4'b0001: alu_res = alu_op1 | alu_op2;
            4'b0010: alu_res = alu_op1 + alu_op2;
            4'b0110: alu_res = alu_op1 - alu_op2;
            4'b1100: alu_res = ~(alu_op1 | alu_op2);
            default: alu_res = 32'h0;
        endcase
        alu_zf = (alu_res == 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] res;
        logic        z;
        logic        e;
    } vec_t;

    vec_t vecs[12];

    // Issue one request with out_ready high and check the full 3-cycle flow.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_op = v.op; funct = v.fn; a = v.a; b = v.b;
        tick;                                   // accept edge E0 -> EXEC
        in_valid = 1'b0;
        chk({tag, "_exec_sel"}, {28'b0, alu_sel}, {28'b0, v.sel});
        chk({tag, "_exec_op1"}, alu_op1, v.a);
        chk({tag, "_exec_vld"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_exec_rdy"}, {31'b0, in_ready}, 32'd0);
        tick;                                   // E1 -> DONE
        chk({tag, "_done_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, result, v.res);
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, v.z});
        chk({tag, "_err"}, {31'b0, err}, {31'b0, v.e});
        tick;                                   // handshake -> IDLE
        chk({tag, "_idle_vld"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_idle_rdy"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        //            op     funct      a             b             sel    res           z     e
        vecs[0]  = '{2'b10, 6'b100000, 32'd5,        32'd7,        4'h2, 32'd12,       1'b0, 1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 32'h1234,     32'h1234,     4'h6, 32'h0,        1'b1, 1'b0};
        vecs[2]  = '{2'b11, 6'b000000, 32'h1234,     32'h1234,     4'h6, 32'h0,        1'b0, 1'b0};
`ifdef ALU_CTRL_SLT_EN
        vecs[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        4'h6, 32'd1,        1'b0, 1'b0};
        vecs[4]  = '{2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 4'h6, 32'd0,        1'b1, 1'b0};
`else
        vecs[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        4'h2, 32'd0,        1'b0, 1'b1};
        vecs[4]  = '{2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 4'h2, 32'd0,        1'b0, 1'b1};
`endif
        vecs[5]  = '{2'b10, 6'b000000, 32'd0,        32'd0,        4'h2, 32'd0,        1'b0, 1'b1};
        vecs[6]  = '{2'b10, 6'b100111, 32'd0,        32'd0,        4'hC, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'b100100, 32'hF0F0,     32'hFF00,     4'h0, 32'hF000,     1'b0, 1'b0};
        vecs[8]  = '{2'b10, 6'b100101, 32'hF0F0,     32'h0F00,     4'h1, 32'hFFF0,     1'b0, 1'b0};
        vecs[9]  = '{2'b00, 6'b100100, 32'hFFFFFFFF, 32'd1,        4'h2, 32'd0,        1'b1, 1'b0};
        vecs[10] = '{2'b10, 6'b100010, 32'd3,        32'd5,        4'h6, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 6'b000000, 32'd1,        32'd2,        4'h6, 32'hFFFFFFFF, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct = 6'b0; a = 32'h0; b = 32'h0;
        tick; tick;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_op1", alu_op1, 32'd0);
        chk("rst_op2", alu_op2, 32'd0);
        chk("rst_sel", {28'b0, alu_sel}, 32'd0);
        chk("rst_zero_err", {30'b0, zero, err}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Backpressure: hold DONE for 5 cycles, new requests must be ignored.
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 2'b00; a = 32'd1; b = 32'd2;
        tick; tick;
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b1; alu_op = 2'b01; a = 32'hDEAD; b = 32'hBEEF;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("bp_hold_result", result, 32'd3);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_op1_held", alu_op1, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of EXEC discards the operation.
        in_valid = 1'b1; alu_op = 2'b00; a = 32'd10; b = 32'd20;
        tick;
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        chk("rstx_valid", {31'b0, out_valid}, 32'd0);
        chk("rstx_result", result, 32'd0);
        chk("rstx_in_ready_low", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rstx_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        chk("rstx_no_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
